mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the core's instruction and data ports. Serves
//   IRAM fetches and DRAM loads/stores from one shared 64-bit-wide array.
//   Decodes a small MMIO window: console TX queue, status word and a
//   free-running mtime counter. Sits in the SoC/testbench top, wired directly
//   to the core's o_iram_*/i_iram_* and o_dram_*/i_dram_* ports.
// PARAMETERS
//   IRAM_AW     62               IRAM address width; the address is a 32-bit-word index
//   DRAM_AW     64               DRAM address width; the address is a byte address, bits [2:0] ignored
//   MEM_LOG2    16               log2 of the number of 64-bit words in the array
//   MMIO_BASE   64'h1000_0000    base byte address of the 16-byte MMIO window
//   TXQ_LOG2    3                log2 of the console TX queue depth
// PORTS
//   clk          in   1         clock
//   rst          in   1         synchronous reset, active-low
//   i_iram_addr  in   IRAM_AW   instruction word address
//   i_iram_re    in   1         fetch request
//   o_iram_insn  out  32        fetched instruction
//   o_iram_valid out  1         o_iram_insn valid this cycle
//   i_dram_addr  in   DRAM_AW   data byte address
//   i_dram_we    in   8         per-byte write enables (lane n = bits [8n+7:8n])
//   i_dram_re    in   1         load request
//   i_dram_din   in   64        store data
//   o_dram_dout  out  64        load data, combinational
//   o_tx_valid   out  1         console byte available
//   o_tx_data    out  8         console byte (head of queue)
//   i_tx_ready   in   1         console sink accepts the byte when o_tx_valid=1
// BEHAVIOUR
//   Reset (edge with rst=0): o_iram_valid=0, o_iram_insn=0, TX queue empty
//     (o_tx_valid=0), overflow flag=0, mtime=0. Array contents are not reset.
//   Reset mid-operation flushes queued bytes. The array is unaffected.
//   IRAM: 1-cycle latency. o_iram_valid(t+1)=i_iram_re(t).
//     o_iram_insn(t+1)=word[addr>>1][addr[0]?63:32 : 31:0].
//     When i_iram_re=0, o_iram_insn holds its value.
//     Array index = address bits modulo 2^MEM_LOG2 (wraps). No fault is raised.
//   DRAM array access (address outside the MMIO window):
//     Read: o_dram_dout = word[addr[MEM_LOG2+2:3]] when i_dram_re=1, else 64'b0.
//     Write: on the clock edge, bytes with we=1 are written.
//     Same-cycle read+write returns pre-write data.
//     A same-cycle IRAM fetch of the written word returns pre-write data.
//   MMIO window, decode on addr[DRAM_AW-1:4]==MMIO_BASE[DRAM_AW-1:4]:
//     offset 0x0 read:  {61'b0, overflow, full, empty}
//     offset 0x0 write, we[0]=1: push din[7:0] into the TX queue. If full and
//       no pop in the same cycle, drop the byte and set the sticky overflow flag.
//     offset 0x8: mtime. Increments by 1 every cycle.
//       In a cycle with any we bit set, written lanes take din, unwritten lanes
//       hold their old value, and there is no increment that cycle.
//     MMIO accesses never touch the array.
//   TX queue: valid/ready handshake; a pop happens when o_tx_valid & i_tx_ready.
//     Push and pop in the same cycle are both performed, including when full.
//     o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
//     A pushed byte is visible on o_tx_valid the next cycle (no bypass).
//     Pointers are TXQ_LOG2+1 bits wide: full/empty via MSB compare, natural wrap.
// CONFIGURATION
//   MEM_RESPONDER_MTIME_EN defined: the mtime counter is present as described.
//   Not defined: offset 0x8 reads 64'b0, writes are ignored, no counter flops.
// STRUCTURE
//   Shared package resp_pkg holds:
//     MMIO offsets (RESP_OFS_STATUS=4'h0, RESP_OFS_MTIME=4'h8)
//     status bit indices (EMPTY=0, FULL=1, OVF=2)
//     word/byte-lane width constants.
//   One sub-module, resp_txq: parameterised synchronous FIFO, 8-bit data,
//     valid/ready pop, push/full/empty ports.
//   Array, decode and mtime live in mem_responder.
// TESTING
//   1. Preload word[0]=64'hAAAA_BBBB_CCCC_DDDD; fetch addr 0 then 1 on
//      consecutive cycles -> 32'hCCCC_DDDD, then 32'hAAAA_BBBB, each valid one
//      cycle after its request.
//   2. Store din=64'h1122_3344_5566_7788 with we=8'h0F to byte addr 0x10 over
//      word 0 -> later load returns 64'h0000_0000_5566_7788. A same-cycle load
//      with the store returns the old word.
//   3. Push 9 bytes 0x41..0x49 with i_tx_ready=0, TXQ_LOG2=3
//      -> status reads 3'b110, queue holds 0x41..0x48.
//      Then raise ready -> 0x41..0x48 drain in order, one per cycle,
//      and status becomes 3'b101.
//   4. Queue full, push 0x5A with i_tx_ready=1 in the same cycle
//      -> no overflow; 0x5A appears last in the drain.
//   5. (MTIME_EN) Write mtime we=8'hFF din=100 -> read next cycle = 100,
//      the cycle after = 101.
//      (no MTIME_EN) read offset 0x8 = 0 always.
//   6. Hold rst=0 while the queue holds 3 bytes and o_iram_valid=1
//      -> next cycle o_tx_valid=0, o_iram_valid=0, status=3'b001,
//      and array contents are intact.

Source files
------------

// File: rtl/resp_pkg.sv
// Shared constants for the memory responder: MMIO offsets, status bit
// positions and the word/byte-lane geometry of the backing array.
package resp_pkg;

  localparam int RESP_WORD_W = 64;
  localparam int RESP_LANE_W = 8;
  localparam int RESP_LANES  = RESP_WORD_W / RESP_LANE_W;
  localparam int RESP_INSN_W = 32;

  localparam logic [3:0] RESP_OFS_STATUS = 4'h0;
  localparam logic [3:0] RESP_OFS_MTIME  = 4'h8;

  localparam int RESP_STAT_EMPTY = 0;
  localparam int RESP_STAT_FULL  = 1;
  localparam int RESP_STAT_OVF   = 2;

endpackage

// File: rtl/resp_txq.sv
// Console TX queue: synchronous byte FIFO with a valid/ready pop side.
// A push into a full queue is accepted only when a pop frees a slot that cycle.
module resp_txq
  import resp_pkg::*;
#(
  parameter int LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [RESP_LANE_W-1:0] i_data,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [RESP_LANE_W-1:0] o_data,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int DEPTH = 2 ** LOG2;

  logic [RESP_LANE_W-1:0] r_mem [DEPTH];
  logic [LOG2:0]          r_wrPtr;
  logic [LOG2:0]          r_rdPtr;
  logic                   w_pop;
  logic                   w_pushOk;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[LOG2] != r_rdPtr[LOG2]) &&
                    (r_wrPtr[LOG2-1:0] == r_rdPtr[LOG2-1:0]);
  assign o_valid  = !o_empty;
  assign o_data   = r_mem[r_rdPtr[LOG2-1:0]];
  assign w_pop    = o_valid && i_ready;
  assign w_pushOk = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr[LOG2-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: shared IRAM/DRAM array plus an MMIO window with the
// console TX queue, status word and mtime (present with MEM_RESPONDER_MTIME_EN).
module mem_responder
  import resp_pkg::*;
#(
  parameter int                 IRAM_AW   = 62,
  parameter int                 DRAM_AW   = 64,
  parameter int                 MEM_LOG2  = 16,
  parameter logic [DRAM_AW-1:0] MMIO_BASE = 64'h1000_0000,
  parameter int                 TXQ_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IRAM_AW-1:0]     i_iram_addr,
  input  logic                   i_iram_re,
  output logic [RESP_INSN_W-1:0] o_iram_insn,
  output logic                   o_iram_valid,
  input  logic [DRAM_AW-1:0]     i_dram_addr,
  input  logic [RESP_LANES-1:0]  i_dram_we,
  input  logic                   i_dram_re,
  input  logic [RESP_WORD_W-1:0] i_dram_din,
  output logic [RESP_WORD_W-1:0] o_dram_dout,
  output logic                   o_tx_valid,
  output logic [RESP_LANE_W-1:0] o_tx_data,
  input  logic                   i_tx_ready
);

  logic [RESP_WORD_W-1:0] r_mem [2 ** MEM_LOG2];
  logic [RESP_INSN_W-1:0] r_iramInsn;
  logic                   r_iramValid;
  logic                   r_ovf;

  logic [MEM_LOG2-1:0]    w_iramIdx;
  logic [MEM_LOG2-1:0]    w_dramIdx;
  logic [RESP_WORD_W-1:0] w_iramWord;
  logic [RESP_WORD_W-1:0] w_dramWord;
  logic [RESP_WORD_W-1:0] w_memWrData;
  logic [RESP_WORD_W-1:0] w_status;
  logic [RESP_WORD_W-1:0] w_mtime;
  logic [3:0]             w_ofs;
  logic                   w_mmioSel;
  logic                   w_statSel;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  // Whole-address casts give the modulo-2^MEM_LOG2 wrap of both ports.
  assign w_iramIdx  = MEM_LOG2'(i_iram_addr >> 1);
  assign w_dramIdx  = MEM_LOG2'(i_dram_addr >> 3);
  assign w_iramWord = r_mem[w_iramIdx];
  assign w_dramWord = r_mem[w_dramIdx];

  assign w_mmioSel = (i_dram_addr[DRAM_AW-1:4] == MMIO_BASE[DRAM_AW-1:4]);
  assign w_ofs     = {i_dram_addr[3], 3'b000};
  assign w_statSel = w_mmioSel && (w_ofs == RESP_OFS_STATUS);
  assign w_push    = w_statSel && i_dram_we[0];
  assign w_pop     = o_tx_valid && i_tx_ready;

  always_comb begin
    w_memWrData = w_dramWord;
    for (int b = 0; b < RESP_LANES; b++) begin
      if (i_dram_we[b]) w_memWrData[b*RESP_LANE_W +: RESP_LANE_W] = i_dram_din[b*RESP_LANE_W +: RESP_LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!w_mmioSel && (|i_dram_we)) begin
      r_mem[w_dramIdx] <= w_memWrData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_iramValid <= 1'b0;
      r_iramInsn  <= '0;
    end else begin
      r_iramValid <= i_iram_re;
      if (i_iram_re) begin
        r_iramInsn <= i_iram_addr[0] ? w_iramWord[63:32] : w_iramWord[31:0];
      end
    end
  end

  assign o_iram_valid = r_iramValid;
  assign o_iram_insn  = r_iramInsn;

  // Overflow is sticky: only a byte actually dropped by the queue sets it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  resp_txq #(
    .LOG2(TXQ_LOG2)
  ) u_txq (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (i_dram_din[RESP_LANE_W-1:0]),
    .i_ready(i_tx_ready),
    .o_valid(o_tx_valid),
    .o_data (o_tx_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

`ifdef MEM_RESPONDER_MTIME_EN
  logic [RESP_WORD_W-1:0] r_mtime;
  logic [RESP_WORD_W-1:0] w_mtimeWrData;
  logic                   w_mtimeWr;

  assign w_mtimeWr = w_mmioSel && (w_ofs == RESP_OFS_MTIME) && (|i_dram_we);

  always_comb begin
    w_mtimeWrData = r_mtime;
    for (int b = 0; b < RESP_LANES; b++) begin
      if (i_dram_we[b]) w_mtimeWrData[b*RESP_LANE_W +: RESP_LANE_W] = i_dram_din[b*RESP_LANE_W +: RESP_LANE_W];
    end
  end

  // A software write replaces the increment for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mtime <= '0;
    end else if (w_mtimeWr) begin
      r_mtime <= w_mtimeWrData;
    end else begin
      r_mtime <= r_mtime + 1'b1;
    end
  end

  assign w_mtime = r_mtime;
`else
  assign w_mtime = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[RESP_STAT_EMPTY] = w_empty;
    w_status[RESP_STAT_FULL]  = w_full;
    w_status[RESP_STAT_OVF]   = r_ovf;
  end

  always_comb begin
    o_dram_dout = '0;
    if (i_dram_re) begin
      if (!w_mmioSel)     o_dram_dout = w_dramWord;
      else if (w_statSel) o_dram_dout = w_status;
      else                o_dram_dout = w_mtime;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of DRAM/MMIO vectors plus
// hand-written IRAM, TX queue, reset and mtime (MEM_RESPONDER_MTIME_EN) sequences.
module tb_mem_responder;

  localparam logic [63:0] MMIO_STAT  = 64'h1000_0000;
  localparam logic [63:0] MMIO_MTIME = 64'h1000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [61:0] i_iram_addr;
  logic        i_iram_re;
  logic [31:0] o_iram_insn;
  logic        o_iram_valid;
  logic [63:0] i_dram_addr;
  logic [7:0]  i_dram_we;
  logic        i_dram_re;
  logic [63:0] i_dram_din;
  logic [63:0] o_dram_dout;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [7:0]  we;
    logic        re;
    logic [63:0] din;
    logic [63:0] expDout;
  } dramVec_t;

  dramVec_t vecs[$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .i_iram_addr (i_iram_addr),
    .i_iram_re   (i_iram_re),
    .o_iram_insn (o_iram_insn),
    .o_iram_valid(o_iram_valid),
    .i_dram_addr (i_dram_addr),
    .i_dram_we   (i_dram_we),
    .i_dram_re   (i_dram_re),
    .i_dram_din  (i_dram_din),
    .o_dram_dout (o_dram_dout),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle's inputs at the falling edge, then settles for checks.
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] we, input logic re,
                               input logic [63:0] din, input logic [61:0] iramAddr,
                               input logic iramRe, input logic txReady);
    @(negedge clk);
    i_dram_addr = addr;
    i_dram_we   = we;
    i_dram_re   = re;
    i_dram_din  = din;
    i_iram_addr = iramAddr;
    i_iram_re   = iramRe;
    i_tx_ready  = txReady;
    #1;
  endtask

  function automatic void addVec(input string name, input logic [63:0] addr, input logic [7:0] we,
                                 input logic re, input logic [63:0] din, input logic [63:0] expDout);
    dramVec_t v;
    v.name = name; v.addr = addr; v.we = we; v.re = re; v.din = din; v.expDout = expDout;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] drainExp [8];

    addVec("preload w0",       64'h0,         8'hFF, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0);
    addVec("load w0",          64'h0,         8'h00, 1'b1, 64'h0,                   64'hAAAA_BBBB_CCCC_DDDD);
    addVec("clear w2",         64'h10,        8'hFF, 1'b0, 64'h0,                   64'h0);
    addVec("w2 rd+wr pre",     64'h10,        8'h0F, 1'b1, 64'h1122_3344_5566_7788, 64'h0);
    addVec("w2 partial",       64'h10,        8'h00, 1'b1, 64'h0,                   64'h0000_0000_5566_7788);
    addVec("preload w3",       64'h18,        8'hFF, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0);
    addVec("w3 rd+wr pre",     64'h18,        8'hF0, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'h0123_4567_89AB_CDEF);
    addVec("w3 upper lanes",   64'h18,        8'h00, 1'b1, 64'h0,                   64'hFFFF_FFFF_89AB_CDEF);
    addVec("w3 low bits ign",  64'h1F,        8'h00, 1'b1, 64'h0,                   64'hFFFF_FFFF_89AB_CDEF);
    addVec("dram wrap",        64'h8_0010,    8'h00, 1'b1, 64'h0,                   64'h0000_0000_5566_7788);
    addVec("status empty",     MMIO_STAT,     8'h00, 1'b1, 64'h0,                   64'h1);
    addVec("mmio no push",     MMIO_STAT,     8'hFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    addVec("w0 untouched",     64'h0,         8'h00, 1'b1, 64'h0,                   64'hAAAA_BBBB_CCCC_DDDD);
    addVec("status still",     MMIO_STAT,     8'h00, 1'b1, 64'h0,                   64'h1);
`ifndef MEM_RESPONDER_MTIME_EN
    addVec("mtime absent",     MMIO_MTIME,    8'h00, 1'b1, 64'h0,                   64'h0);
`endif

    // Reset state.
    rst = 1'b0;
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b0);
    applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("reset iram_valid", 64'(o_iram_valid), 64'h0);
    checkOutput("reset iram_insn",  64'(o_iram_insn),  64'h0);
    checkOutput("reset tx_valid",   64'(o_tx_valid),   64'h0);
    checkOutput("reset status",     o_dram_dout,       64'h1);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].din, 62'h0, 1'b0, 1'b0);
      checkOutput(vecs[i].name, o_dram_dout, vecs[i].expDout);
    end

    // IRAM fetches: 1-cycle latency, hold, wrap and read-before-write.
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b1, 1'b0);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h1, 1'b1, 1'b0);
    checkOutput("fetch0 valid", 64'(o_iram_valid), 64'h1);
    checkOutput("fetch0 insn",  64'(o_iram_insn),  64'hCCCC_DDDD);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h4, 1'b0, 1'b0);
    checkOutput("fetch1 valid", 64'(o_iram_valid), 64'h1);
    checkOutput("fetch1 insn",  64'(o_iram_insn),  64'hAAAA_BBBB);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h2_0000, 1'b1, 1'b0);
    checkOutput("idle valid",   64'(o_iram_valid), 64'h0);
    checkOutput("idle hold",    64'(o_iram_insn),  64'hAAAA_BBBB);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h4, 1'b1, 1'b0);
    checkOutput("fetch wrap",   64'(o_iram_insn),  64'hCCCC_DDDD);
    applyStimulus(64'h18, 8'h0F, 1'b0, 64'h0000_0000_1234_5678, 62'h6, 1'b1, 1'b0);
    checkOutput("fetch w2 low", 64'(o_iram_insn),  64'h5566_7788);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h6, 1'b1, 1'b0);
    checkOutput("fetch pre-wr", 64'(o_iram_insn),  64'h89AB_CDEF);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("fetch post-wr", 64'(o_iram_insn), 64'h1234_5678);

    // Overfill the queue, then drain it.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(MMIO_STAT, 8'h01, 1'b0, 64'(8'h41 + i), 62'h0, 1'b0, 1'b0);
    end
    applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("ovf status", o_dram_dout, 64'h6);
    checkOutput("ovf head",   64'(o_tx_data), 64'h41);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b1);
      checkOutput("drain valid", 64'(o_tx_valid), 64'h1);
      checkOutput("drain data",  64'(o_tx_data),  64'(8'h41 + j));
    end
    applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b1);
    checkOutput("drained valid",  64'(o_tx_valid), 64'h0);
    checkOutput("drained status", o_dram_dout,     64'h5);

    // Reset with bytes queued and a fetch in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(MMIO_STAT, 8'h01, 1'b0, 64'(8'h71 + i), 62'h0, 1'b0, 1'b0);
    end
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b1, 1'b0);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("pre-rst iram_valid", 64'(o_iram_valid), 64'h1);
    checkOutput("pre-rst tx_valid",   64'(o_tx_valid),   64'h1);
    rst = 1'b0;
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("rst tx_valid",   64'(o_tx_valid),   64'h0);
    checkOutput("rst iram_valid", 64'(o_iram_valid), 64'h0);
    rst = 1'b1;
    applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("rst status", o_dram_dout, 64'h1);
    applyStimulus(64'h10, 8'h00, 1'b1, 64'h0, 62'h1, 1'b1, 1'b0);
    checkOutput("rst array w2", o_dram_dout, 64'h0000_0000_5566_7788);
    applyStimulus(64'h0, 8'h00, 1'b0, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("rst array w0", 64'(o_iram_insn), 64'hAAAA_BBBB);

    // Push into a full queue while a pop frees a slot.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(MMIO_STAT, 8'h01, 1'b0, 64'(8'h61 + i), 62'h0, 1'b0, 1'b0);
    end
    applyStimulus(MMIO_STAT, 8'h01, 1'b1, 64'h5A, 62'h0, 1'b0, 1'b1);
    checkOutput("full status", o_dram_dout,     64'h2);
    checkOutput("full head",   64'(o_tx_data),  64'h61);
    for (int k = 0; k < 7; k++) drainExp[k] = 8'h62 + 8'(k);
    drainExp[7] = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b1);
      if (k == 0) checkOutput("no ovf status", o_dram_dout, 64'h2);
      checkOutput("push-pop valid", 64'(o_tx_valid), 64'h1);
      checkOutput("push-pop data",  64'(o_tx_data),  64'(drainExp[k]));
    end
    applyStimulus(MMIO_STAT, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("push-pop end status", o_dram_dout, 64'h1);

`ifdef MEM_RESPONDER_MTIME_EN
    applyStimulus(MMIO_MTIME, 8'hFF, 1'b0, 64'd100, 62'h0, 1'b0, 1'b0);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime written", o_dram_dout, 64'd100);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime incr", o_dram_dout, 64'd101);
    applyStimulus(MMIO_MTIME, 8'h02, 1'b0, 64'hFFFF_FFFF_FFFF_05FF, 62'h0, 1'b0, 1'b0);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime lane write", o_dram_dout, 64'h0566);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime lane incr", o_dram_dout, 64'h0567);
`else
    applyStimulus(MMIO_MTIME, 8'hFF, 1'b0, 64'd100, 62'h0, 1'b0, 1'b0);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime ignored wr", o_dram_dout, 64'h0);
    applyStimulus(MMIO_MTIME, 8'h00, 1'b1, 64'h0, 62'h0, 1'b0, 1'b0);
    checkOutput("mtime stays zero", o_dram_dout, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
